// File: rtl/l2_sram_march_bist.sv
// l2_sram_march_bist
//   March C- style self-test engine that drives the single-port L2 SRAM macro
//   interface directly.
//
//   Test sequence over words 0..DEPTH-1 with data background P:
//     E0 up   : w P
//     E1 up   : r P,  w ~P
//     E2 down : r ~P, w P
//     E3 up   : r P
//   A final DRAIN cycle retires the last read compare. Then the engine parks
//   in DONE until the next start.
//
// Ports
//   CLK, RSTN            clock, asynchronous active-low reset
//   start_i, pattern_i   start request (honoured in IDLE/DONE), background P
//   busy_o, done_o       test running / finished (held until next start)
//   fail_o               sticky mismatch flag
//   fail_addr_o          address of the first mismatch
//   fail_count_o         saturating mismatch count
//   CEN, WEN, BEN        SRAM strobes, active-low, registered
//   A, D                 SRAM word address / write data, registered
//   Q                    SRAM read data, valid the cycle after a read

// Per-byte-lane read compare. Any bit difference flags the lane.
module l2_bist_lane_cmp #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_q,
  input  logic [W-1:0] i_exp,
  output logic         o_mis
);
  assign o_mis = |(i_q ^ i_exp);
endmodule

module l2_sram_march_bist #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 29184,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    start_i,
  input  logic [DATA_WIDTH-1:0]   pattern_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    fail_o,
  output logic [ADDR_WIDTH-1:0]   fail_addr_o,
  output logic [CNT_WIDTH-1:0]    fail_count_o,
  output logic                    CEN,
  output logic                    WEN,
  output logic [DATA_WIDTH/8-1:0] BEN,
  output logic [ADDR_WIDTH-1:0]   A,
  output logic [DATA_WIDTH-1:0]   D,
  input  logic [DATA_WIDTH-1:0]   Q
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_E0_W  = 4'd1;
  localparam logic [3:0] S_E1_R  = 4'd2;
  localparam logic [3:0] S_E1_W  = 4'd3;
  localparam logic [3:0] S_E2_R  = 4'd4;
  localparam logic [3:0] S_E2_W  = 4'd5;
  localparam logic [3:0] S_E3_R  = 4'd6;
  localparam logic [3:0] S_DRAIN = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  // r_state names the access currently presented on the port; the port
  // registers are loaded from the next state so they always line up with it.
  logic [3:0]            r_state, w_nxt_state;
  logic [ADDR_WIDTH-1:0] r_addr, w_nxt_addr;
  logic [DATA_WIDTH-1:0] r_pat, w_pat;
  logic                  w_start, w_last, w_first;
  logic                  w_nxt_rd, w_nxt_wr;
  logic [DATA_WIDTH-1:0] w_nxt_d, w_nxt_exp;

  logic                  r_cen, r_wen;
  logic [NB-1:0]         r_ben;
  logic [DATA_WIDTH-1:0] r_d;
  logic [DATA_WIDTH-1:0] r_exp;      // expected data of the read on the port

  logic                  r_rd_vld;   // read issued last cycle, Q valid now
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [DATA_WIDTH-1:0] r_rd_exp;
  logic [NB-1:0]         w_lane_mis;
  logic                  w_mis;

  logic                  r_busy, r_done, r_fail;
  logic [ADDR_WIDTH-1:0] r_fail_addr;
  logic [CNT_WIDTH-1:0]  r_fail_cnt;

  assign w_start = start_i & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_pat   = w_start ? pattern_i : r_pat;
  assign w_last  = (r_addr == LAST);
  assign w_first = (r_addr == '0);

  // Terminal addresses are detected explicitly so the counter never wraps.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_addr  = r_addr;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) begin
          w_nxt_state = S_E0_W;
          w_nxt_addr  = '0;
        end
      end
      S_E0_W: begin
        if (w_last) begin
          w_nxt_state = S_E1_R;
          w_nxt_addr  = '0;
        end else begin
          w_nxt_addr  = r_addr + ADDR_WIDTH'(1);
        end
      end
      S_E1_R: w_nxt_state = S_E1_W;
      S_E1_W: begin
        if (w_last) begin
          w_nxt_state = S_E2_R;
          w_nxt_addr  = LAST;
        end else begin
          w_nxt_state = S_E1_R;
          w_nxt_addr  = r_addr + ADDR_WIDTH'(1);
        end
      end
      S_E2_R: w_nxt_state = S_E2_W;
      S_E2_W: begin
        if (w_first) begin
          w_nxt_state = S_E3_R;
          w_nxt_addr  = '0;
        end else begin
          w_nxt_state = S_E2_R;
          w_nxt_addr  = r_addr - ADDR_WIDTH'(1);
        end
      end
      S_E3_R: begin
        if (w_last) w_nxt_state = S_DRAIN;
        else        w_nxt_addr  = r_addr + ADDR_WIDTH'(1);
      end
      S_DRAIN: w_nxt_state = S_DONE;
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_addr  = '0;
      end
    endcase
  end

  assign w_nxt_rd  = (w_nxt_state == S_E1_R) | (w_nxt_state == S_E2_R) |
                     (w_nxt_state == S_E3_R);
  assign w_nxt_wr  = (w_nxt_state == S_E0_W) | (w_nxt_state == S_E1_W) |
                     (w_nxt_state == S_E2_W);
  assign w_nxt_d   = ~w_nxt_wr ? '0 : ((w_nxt_state == S_E1_W) ? ~w_pat : w_pat);
  assign w_nxt_exp = (w_nxt_state == S_E2_R) ? ~w_pat : w_pat;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_pat   <= '0;
      r_cen   <= 1'b1;
      r_wen   <= 1'b1;
      r_ben   <= '1;
      r_d     <= '0;
      r_exp   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_addr  <= w_nxt_addr;
      r_pat   <= w_pat;
      r_cen   <= ~(w_nxt_rd | w_nxt_wr);
      r_wen   <= ~w_nxt_wr;
      r_ben   <= (w_nxt_rd | w_nxt_wr) ? '0 : '1;
      r_d     <= w_nxt_d;
      r_exp   <= w_nxt_exp;
      r_busy  <= (w_nxt_state != S_IDLE) & (w_nxt_state != S_DONE);
      r_done  <= (w_nxt_state == S_DONE);
    end
  end

  // Capture the read context in the cycle the macro samples it; the compare
  // then happens while the next access (possibly a write to the same word)
  // is on the port, which cannot disturb the already-launched Q.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_rd_vld  <= 1'b0;
      r_rd_addr <= '0;
      r_rd_exp  <= '0;
    end else begin
      r_rd_vld  <= ~r_cen & r_wen;
      r_rd_addr <= r_addr;
      r_rd_exp  <= r_exp;
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_lane
    l2_bist_lane_cmp #(.W(8)) u_cmp (
      .i_q   (Q[b*8 +: 8]),
      .i_exp (r_rd_exp[b*8 +: 8]),
      .o_mis (w_lane_mis[b])
    );
  end

  assign w_mis = r_rd_vld & (|w_lane_mis);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_cnt  <= '0;
    end else if (w_start) begin
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_cnt  <= '0;
    end else if (w_mis) begin
      r_fail <= 1'b1;
      if (!r_fail)                r_fail_addr <= r_rd_addr;
      if (r_fail_cnt != CNT_MAX)  r_fail_cnt  <= r_fail_cnt + CNT_WIDTH'(1);
    end
  end

  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign fail_o       = r_fail;
  assign fail_addr_o  = r_fail_addr;
  assign fail_count_o = r_fail_cnt;
  assign CEN          = r_cen;
  assign WEN          = r_wen;
  assign BEN          = r_ben;
  assign A            = r_addr;
  assign D            = r_d;

endmodule

// File: tb/tb_l2_sram_march_bist.sv
// Bench for l2_sram_march_bist with DEPTH=16 and a 2-bit mismatch counter.
// A behavioural SRAM with selectable faults sits on the port; the expected
// access stream and the expected result of each run are queued at start and
// retired as the DUT produces port accesses and reaches DONE.
module tb_l2_sram_march_bist;
  localparam int AW = 15, DW = 32, NB = 4, DEPTH = 16, CW = 2;

  typedef struct packed {
    logic          fail;
    logic [AW-1:0] addr;
    logic [CW-1:0] cnt;
  } res_t;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          start_i = 1'b0;
  logic [DW-1:0] pattern_i = '0;
  logic          busy_o, done_o, fail_o;
  logic [AW-1:0] fail_addr_o;
  logic [CW-1:0] fail_count_o;
  logic          CEN, WEN;
  logic [NB-1:0] BEN;
  logic [AW-1:0] A;
  logic [DW-1:0] D;
  logic [DW-1:0] Q = '0;

  l2_sram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RSTN(RSTN), .start_i(start_i), .pattern_i(pattern_i),
    .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .fail_addr_o(fail_addr_o),
    .fail_count_o(fail_count_o), .CEN(CEN), .WEN(WEN), .BEN(BEN), .A(A), .D(D), .Q(Q)
  );

  always #5 CLK = ~CLK;

  int          n_vec = 0, n_mis = 0;
  int          mode = 0;     // 0 ideal, 1 addr5 bit3 stuck-1, 2 words 8/9 share a cell, 3 inverted reads
  int          acc_cnt = 0, busy_tot = 0;
  logic [DW-1:0] mem [DEPTH];
  logic [51:0] acc_q [$];
  res_t        res_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // SRAM model, 1-cycle read latency
  always @(posedge CLK) begin
    if (!CEN) begin
      if (!WEN) begin
        if (BEN == '0) begin
          mem[A[3:0]] <= D;
          if (mode == 2 && (A == 15'd8 || A == 15'd9)) begin
            mem[8] <= D;
            mem[9] <= D;
          end
        end
      end else begin
        case (mode)
          1:       Q <= mem[A[3:0]] | ((A == 15'd5) ? 32'h8 : 32'h0);
          3:       Q <= ~mem[A[3:0]];
          default: Q <= mem[A[3:0]];
        endcase
      end
    end
  end

  // Port monitor: every access retires one queued expectation; with nothing
  // queued the port must stay idle.
  always @(negedge CLK) begin
    if (!CEN) acc_cnt <= acc_cnt + 1;
    if (busy_o) busy_tot <= busy_tot + 1;
    if (acc_q.size() == 0)
      chk("port_idle", 64'(CEN), 64'(1));
    else if (!CEN)
      chk("port_acc", 64'({BEN, WEN, A, (WEN ? 32'h0 : D)}), 64'(acc_q.pop_front()));
  end

  function automatic logic [51:0] acc(input logic wen, input int a, input logic [DW-1:0] d);
    return {4'h0, wen, AW'(a), (wen ? 32'h0 : d)};
  endfunction

  task automatic push_seq(input logic [DW-1:0] p);
    for (int a = 0; a < DEPTH; a++) acc_q.push_back(acc(1'b0, a, p));
    for (int a = 0; a < DEPTH; a++) begin
      acc_q.push_back(acc(1'b1, a, '0));
      acc_q.push_back(acc(1'b0, a, ~p));
    end
    for (int a = DEPTH - 1; a >= 0; a--) begin
      acc_q.push_back(acc(1'b1, a, '0));
      acc_q.push_back(acc(1'b0, a, p));
    end
    for (int a = 0; a < DEPTH; a++) acc_q.push_back(acc(1'b1, a, '0));
  endtask

  task automatic run(input logic [DW-1:0] p, input int md, input logic efail,
                     input logic [AW-1:0] eaddr, input logic [CW-1:0] ecnt, input bit stray);
    int   base, i;
    res_t r;
    mode = md;
    push_seq(p);
    res_q.push_back('{efail, eaddr, ecnt});
    @(negedge CLK);
    base = busy_tot;
    start_i = 1'b1;
    pattern_i = p;
    @(negedge CLK);
    start_i = 1'b0;
    #1;
    chk("start_busy", 64'(busy_o), 64'(1));
    chk("start_done", 64'(done_o), 64'(0));
    chk("start_fail", 64'(fail_o), 64'(0));
    chk("start_cnt", 64'(fail_count_o), 64'(0));
    chk("start_faddr", 64'(fail_addr_o), 64'(0));
    if (stray) begin
      repeat (9) @(negedge CLK);
      start_i = 1'b1;
      pattern_i = ~p;
      @(negedge CLK);
      start_i = 1'b0;
    end
    i = 0;
    while (!done_o && i < 400) begin
      @(negedge CLK);
      i++;
    end
    #1;
    chk("done", 64'(done_o), 64'(1));
    chk("busy_cycles", 64'(busy_tot - base), 64'(6 * DEPTH + 1));
    chk("acc_left", 64'(acc_q.size()), 64'(0));
    chk("busy_end", 64'(busy_o), 64'(0));
    r = res_q.pop_front();
    chk("fail", 64'(fail_o), 64'(r.fail));
    chk("fail_addr", 64'(fail_addr_o), 64'(r.addr));
    chk("fail_cnt", 64'(fail_count_o), 64'(r.cnt));
    acc_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cen"}, 64'(CEN), 64'(1));
    chk({tag, "_wen"}, 64'(WEN), 64'(1));
    chk({tag, "_ben"}, 64'(BEN), 64'(4'hF));
    chk({tag, "_a"}, 64'(A), 64'(0));
    chk({tag, "_d"}, 64'(D), 64'(0));
    chk({tag, "_busy"}, 64'(busy_o), 64'(0));
    chk({tag, "_done"}, 64'(done_o), 64'(0));
    chk({tag, "_fail"}, 64'(fail_o), 64'(0));
    chk({tag, "_faddr"}, 64'(fail_addr_o), 64'(0));
    chk({tag, "_cnt"}, 64'(fail_count_o), 64'(0));
  endtask

  initial begin
    int base, i;
    for (int a = 0; a < DEPTH; a++) mem[a] = '0;
    repeat (3) @(negedge CLK);
    #1;
    chk_reset_vals("rst");
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);

    run(32'h5A5AA5A5, 0, 1'b0, 15'd0, 2'd0, 1'b0);   // ideal
    run(32'h00000000, 1, 1'b1, 15'd5, 2'd2, 1'b0);   // stuck-at bit
    run(32'h5A5AA5A5, 2, 1'b1, 15'd9, 2'd2, 1'b0);   // coupled 8/9
    run(32'h12345678, 3, 1'b1, 15'd0, 2'd3, 1'b0);   // every read wrong, count saturates
    run(32'h0F0FF0F0, 0, 1'b0, 15'd0, 2'd0, 1'b1);   // restart from failed DONE, stray start

    // Asynchronous reset during E2 read of address 7 (65th access)
    mode = 3;
    push_seq(32'hC3C33C3C);
    @(negedge CLK);
    base = acc_cnt;
    start_i = 1'b1;
    pattern_i = 32'hC3C33C3C;
    @(negedge CLK);
    start_i = 1'b0;
    i = 0;
    while ((acc_cnt - base) < 65 && i < 300) begin
      @(negedge CLK);
      #1;
      i++;
    end
    chk("e2_reach", 64'(acc_cnt - base), 64'(65));
    chk("e2_addr", 64'(A), 64'(7));
    chk("e2_rd", 64'({CEN, WEN}), 64'(2'b01));
    chk("e2_fail_pre", 64'(fail_o), 64'(1));
    RSTN = 1'b0;
    #1;
    acc_q.delete();
    chk_reset_vals("midrst");
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (20) @(negedge CLK);
    #1;
    chk("post_busy", 64'(busy_o), 64'(0));
    chk("post_done", 64'(done_o), 64'(0));
    chk("post_cen", 64'(CEN), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
